// File: rtl/demux_tdm.sv
// demux_tdm: time-division demultiplexer, one TDM word stream -> four channels.
// A frame is four valid words (slot 0 flagged by frame_start). The channel
// outputs are updated together, one clock after the last word of the frame.
// Optional feature: define DEMUX_PARITY_EN so that each frame is followed by
// a parity word. Bit 0 of that word is P. The frame is committed only when
// the XOR of all data bits and P is 0; otherwise par_err pulses.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   din, din_valid    TDM data word and its valid strobe
//   frame_start       marks din as slot 0 of a new frame
//   a, b, c, d        registered channel outputs (slots 0..3)
//   s1, s0            index of the next slot expected (s1 = MSB)
//   frame_valid       one-cycle pulse when a..d are updated
//   par_err           one-cycle pulse on parity failure (0 without parity)
module demux_tdm #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          frame_start,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [DW-1:0] c,
  output logic [DW-1:0] d,
  output logic          s1,
  output logic          s0,
  output logic          frame_valid,
  output logic          par_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
`ifdef DEMUX_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [DW-1:0] sh_q [4];
  logic [DW-1:0] sh_d [4];
  logic [DW-1:0] a_d, b_d, c_d, d_d;
  logic          fv_d;

`ifdef DEMUX_PARITY_EN
  logic          pe_d;
  logic          parity_c;

  // Even parity across the four buffered words plus the P bit of din.
  assign parity_c = ^{sh_q[0], sh_q[1], sh_q[2], sh_q[3], din[0]};
`endif

  assign s1 = slot_q[1];
  assign s0 = slot_q[0];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    a_d     = a;
    b_d     = b;
    c_d     = c;
    d_d     = d;
    fv_d    = 1'b0;
`ifdef DEMUX_PARITY_EN
    pe_d    = 1'b0;
`endif

    if (din_valid && frame_start) begin
      // A new frame start overrides any partial frame, whatever the state.
      sh_d[0] = din;
      slot_d  = 2'd1;
      state_d = RUN;
    end else if (din_valid) begin
      case (state_q)
        RUN: begin
          sh_d[slot_q] = din;
          if (slot_q == 2'd3) begin
            slot_d = 2'd0;
`ifdef DEMUX_PARITY_EN
            state_d = PAR;
`else
            // The slot-3 word goes straight to d, so the commit needs no extra cycle.
            a_d     = sh_q[0];
            b_d     = sh_q[1];
            c_d     = sh_q[2];
            d_d     = din;
            fv_d    = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end
`ifdef DEMUX_PARITY_EN
        PAR: begin
          if (parity_c == 1'b0) begin
            a_d  = sh_q[0];
            b_d  = sh_q[1];
            c_d  = sh_q[2];
            d_d  = sh_q[3];
            fv_d = 1'b1;
          end else begin
            pe_d = 1'b1;
          end
          state_d = IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= 2'd0;
      sh_q        <= '{default: '0};
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sh_q        <= sh_d;
      a           <= a_d;
      b           <= b_d;
      c           <= c_d;
      d           <= d_d;
      frame_valid <= fv_d;
    end
  end

`ifdef DEMUX_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= pe_d;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_tdm.sv
// tb_demux_tdm: directed, self-checking bench for demux_tdm.
// Two instances are driven: one with DW=1 and one with DW=8. Completed frames
// are queued as the stimulus is driven. A negedge monitor pops the queue on
// every frame_valid pulse.
module tb_demux_tdm;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       v1, fs1;
  logic [0:0] d1;
  logic [0:0] a1, b1, c1, dd1;
  logic       s1_1, s0_1, fv1, pe1;

  logic       v8, fs8;
  logic [7:0] d8;
  logic [7:0] a8, b8, c8, dd8;
  logic       s1_8, s0_8, fv8, pe8;

  frame_t q1[$];
  frame_t q8[$];
  int n_cmp = 0;
  int n_err = 0;
  int fv1_cnt = 0;
  int fv8_cnt = 0;
  int pe1_cnt = 0;
  int cnt0;

  demux_tdm #(.DW(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(d1), .din_valid(v1), .frame_start(fs1),
    .a(a1), .b(b1), .c(c1), .d(dd1), .s1(s1_1), .s0(s0_1),
    .frame_valid(fv1), .par_err(pe1)
  );

  demux_tdm #(.DW(8)) u_dut8 (
    .clk(clk), .rst(rst), .din(d8), .din_valid(v8), .frame_start(fs8),
    .a(a8), .b(b8), .c(c8), .d(dd8), .s1(s1_8), .s0(s0_8),
    .frame_valid(fv8), .par_err(pe8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: each frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (fv8) begin
      fv8_cnt++;
      chk("fv8_pending", 32'(q8.size()), 32'd1);
      if (q8.size() > 0) begin
        frame_t e;
        e = q8.pop_front();
        chk("dut8_a", 32'(a8), 32'(e.a));
        chk("dut8_b", 32'(b8), 32'(e.b));
        chk("dut8_c", 32'(c8), 32'(e.c));
        chk("dut8_d", 32'(dd8), 32'(e.d));
      end
    end
    if (fv1) begin
      fv1_cnt++;
      chk("fv1_pending", 32'(q1.size()), 32'd1);
      if (q1.size() > 0) begin
        frame_t e;
        e = q1.pop_front();
        chk("dut1_a", 32'(a1), 32'(e.a));
        chk("dut1_b", 32'(b1), 32'(e.b));
        chk("dut1_c", 32'(c1), 32'(e.c));
        chk("dut1_d", 32'(dd1), 32'(e.d));
      end
    end
    if (pe1) pe1_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w8(input logic fs, input logic [7:0] dat);
    v8 = 1'b1; fs8 = fs; d8 = dat;
    tick();
    v8 = 1'b0; fs8 = 1'b0; d8 = 8'h00;
  endtask

  task automatic w1(input logic fs, input logic dat);
    v1 = 1'b1; fs1 = fs; d1 = dat;
    tick();
    v1 = 1'b0; fs1 = 1'b0; d1 = 1'b0;
  endtask

  // Trailing parity word for a frame whose data XOR is x (no-op without parity).
  task automatic fin8(input logic [7:0] x);
`ifdef DEMUX_PARITY_EN
    w8(1'b0, {7'd0, ^x});
`else
    if (x === 8'hxx) $display("note: unknown frame xor");
`endif
  endtask

  task automatic fin1(input logic x);
`ifdef DEMUX_PARITY_EN
    w1(1'b0, x);
`else
    if (x === 1'bx) $display("note: unknown frame xor");
`endif
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_abcd"}, {a8, b8, c8, dd8}, 32'd0);
    chk({tag, "_s"}, 32'({s1_8, s0_8}), 32'd0);
    chk({tag, "_fv"}, 32'(fv8), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; fs1 = 1'b0; d1 = 1'b0;
    v8 = 1'b0; fs8 = 1'b0; d8 = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state on both instances.
    chk_zero8("rst8");
    chk("rst8_pe", 32'(pe8), 32'd0);
    chk("rst1_abcd", 32'({a1, b1, c1, dd1}), 32'd0);
    chk("rst1_s", 32'({s1_1, s0_1}), 32'd0);
    chk("rst1_fvpe", 32'({fv1, pe1}), 32'd0);

    // Long idle after reset: nothing moves.
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_ctl", 32'({s1_8, s0_8, fv8, pe8}), 32'd0);
    end
    chk_zero8("idle_end");

    // Gapped frame; slot index steps 1, 2, 3, 0 and outputs wait for commit.
    w8(1'b1, 8'h11);
    chk("gap_s_1", 32'({s1_8, s0_8}), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("gap_s_hold", 32'({s1_8, s0_8}), 32'd1);
    w8(1'b0, 8'h22);
    chk("gap_s_2", 32'({s1_8, s0_8}), 32'd2);
    for (int i = 0; i < 3; i++) tick();
    w8(1'b0, 8'h33);
    chk("gap_s_3", 32'({s1_8, s0_8}), 32'd3);
    for (int i = 0; i < 3; i++) tick();
    chk("gap_no_early", {a8, b8, c8, dd8}, 32'd0);
    cnt0 = fv8_cnt;
    q8.push_back('{8'h11, 8'h22, 8'h33, 8'h44});
    w8(1'b0, 8'h44);
    chk("gap_s_0", 32'({s1_8, s0_8}), 32'd0);
    fin8(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
    chk("gap_fv_hi", 32'(fv8), 32'd1);
    tick();
    chk("gap_fv_lo", 32'(fv8), 32'd0);
    chk("gap_fv_once", 32'(fv8_cnt - cnt0), 32'd1);
    chk("gap_hold_abcd", {a8, b8, c8, dd8}, 32'h11223344);

    // Restarted frame: the partial AA/BB frame is discarded.
    cnt0 = fv8_cnt;
    w8(1'b1, 8'hAA);
    w8(1'b0, 8'hBB);
    chk("restart_s", 32'({s1_8, s0_8}), 32'd2);
    w8(1'b1, 8'h01);
    chk("restart_s1", 32'({s1_8, s0_8}), 32'd1);
    chk("restart_no_fv", 32'(fv8), 32'd0);
    w8(1'b0, 8'h02);
    w8(1'b0, 8'h03);
    chk("restart_old_out", {a8, b8, c8, dd8}, 32'h11223344);
    q8.push_back('{8'h01, 8'h02, 8'h03, 8'h04});
    w8(1'b0, 8'h04);
    fin8(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    chk("restart_fv_hi", 32'(fv8), 32'd1);
    tick();
    chk("restart_fv_once", 32'(fv8_cnt - cnt0), 32'd1);

    // Reset in mid-frame, then headless words are ignored.
    w8(1'b1, 8'h55);
    w8(1'b0, 8'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero8("midrst");
    chk("midrst_pe", 32'(pe8), 32'd0);
    cnt0 = fv8_cnt;
    w8(1'b0, 8'h77);
    w8(1'b0, 8'h88);
    w8(1'b0, 8'h99);
    w8(1'b0, 8'hAA);
    w8(1'b0, 8'h01);
    tick();
    chk_zero8("headless");
    chk("headless_fv", 32'(fv8_cnt - cnt0), 32'd0);

    // DW=1 back-to-back frame 1, 0, 1, 1.
    w1(1'b1, 1'b1);
    w1(1'b0, 1'b0);
    w1(1'b0, 1'b1);
    chk("dw1_no_early", 32'({a1, b1, c1, dd1}), 32'd0);
    q1.push_back('{8'd1, 8'd0, 8'd1, 8'd1});
    w1(1'b0, 1'b1);
    fin1(1'b1);
    chk("dw1_fv_hi", 32'(fv1), 32'd1);
    tick();
    chk("dw1_fv_lo", 32'(fv1), 32'd0);
    chk("dw1_hold", 32'({a1, b1, c1, dd1}), 32'b1011);
    chk("dw1_pe", 32'(pe1_cnt), 32'd0);

`ifdef DEMUX_PARITY_EN
    // Parity good: 1,1,0,1 with P=1 commits.
    cnt0 = fv1_cnt;
    w1(1'b1, 1'b1);
    w1(1'b0, 1'b1);
    w1(1'b0, 1'b0);
    w1(1'b0, 1'b1);
    chk("par_wait_fv", 32'(fv1), 32'd0);
    chk("par_wait_s", 32'({s1_1, s0_1}), 32'd0);
    q1.push_back('{8'd1, 8'd1, 8'd0, 8'd1});
    w1(1'b0, 1'b1);
    chk("par_ok_fv", 32'(fv1), 32'd1);
    chk("par_ok_pe", 32'(pe1), 32'd0);
    tick();
    chk("par_ok_once", 32'(fv1_cnt - cnt0), 32'd1);

    // Parity bad: same data with P=0 raises par_err, outputs unchanged.
    cnt0 = fv1_cnt;
    w1(1'b1, 1'b1);
    w1(1'b0, 1'b1);
    w1(1'b0, 1'b0);
    w1(1'b0, 1'b1);
    w1(1'b0, 1'b0);
    chk("par_bad_pe", 32'(pe1), 32'd1);
    chk("par_bad_fv", 32'(fv1), 32'd0);
    tick();
    chk("par_bad_pe_lo", 32'(pe1), 32'd0);
    chk("par_bad_hold", 32'({a1, b1, c1, dd1}), 32'b1101);
    chk("par_bad_nofv", 32'(fv1_cnt - cnt0), 32'd0);
`endif

    tick();
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_tdm.md
DEMUX_TDM -- requirements
Module: demux_tdm

Interface
REQ-001 SHALL have parameter DW, default 1, giving the data width in bits of din and of each output channel.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port din, input, DW bits: time-division-multiplexed data word.
REQ-005 SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-006 SHALL have port frame_start, input, 1 bit: when high with din_valid, din is slot 0 of a new frame.
REQ-007 SHALL have ports a, b, c, d, output, DW bits each: registered channel outputs for slots 0, 1, 2 and 3.
REQ-008 SHALL have port s1, output, 1 bit, and port s0, output, 1 bit: index of the next slot expected, with s1 as the MSB.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a..d are updated.
REQ-010 SHALL have port par_err, output, 1 bit: one-cycle pulse on a parity failure.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and PAR; PAR is reachable only when DEMUX_PARITY_EN is defined.
REQ-012 SHALL hold four shadow registers sh0..sh3 (DW bits each) and a 2-bit slot counter driving s1/s0.
REQ-013 SHALL, in IDLE, ignore din_valid when frame_start is low; state, slot and outputs do not change.
REQ-014 SHALL, in any state, on din_valid=1 with frame_start=1: capture din into sh0, set slot=1, enter RUN, and discard any partial frame without pulsing frame_valid or par_err.
REQ-015 SHALL, in RUN, on din_valid=1 with frame_start=0: capture din into sh[slot] and increment slot.
REQ-016 SHALL, in any state with din_valid=0, hold state, slot and shadow registers; gaps of any length are legal.
REQ-017 SHALL, when slot 3 is captured without parity: on the same edge load a=sh0, b=sh1, c=sh2, d=din, drive frame_valid=1 for exactly one cycle, set slot=0, and enter IDLE.
REQ-018 SHALL update outputs only atomically at frame completion; a..d hold their values between frames, so latency from the slot-3 word is 1 clock.
REQ-019 SHALL keep frame_valid and par_err low in every cycle not named in REQ-017 or REQ-022.

Reset
REQ-020 SHALL, on a clk edge with rst=1: set a=b=c=d=0, sh0..sh3=0, slot=0 (s1=s0=0), frame_valid=0, par_err=0 and state=IDLE; rst overrides all other inputs, including in mid-frame.

Configuration
REQ-021 SHALL enable parity when the macro DEMUX_PARITY_EN is defined; without it, PAR is absent, REQ-017 applies, and par_err is tied to 0.
REQ-022 SHALL, with DEMUX_PARITY_EN defined: after the slot-3 capture go to PAR (slot stays 0) instead of committing; the next din_valid word without frame_start carries bit din[0]=P.
REQ-023 SHALL, in PAR: if the XOR reduction of sh0..sh3 and P equals 0, commit a..d=sh0..sh3 and pulse frame_valid for one cycle; otherwise leave a..d unchanged and pulse par_err for one cycle; then enter IDLE either way.
REQ-024 SHALL, in PAR, treat frame_start=1 with din_valid=1 as a new frame start per REQ-014, with no commit and no par_err.

Verification
REQ-025 SHALL cover: DW=1, no parity, frame_start with 1, then 0, 1, 1 in consecutive valid cycles -> one edge after the 4th word a=1, b=0, c=1, d=1 and frame_valid high for 1 cycle.
REQ-026 SHALL cover: DW=8, words 0x11, 0x22, 0x33, 0x44 with 3 idle cycles between each -> a..d=0x11/0x22/0x33/0x44 with a single frame_valid pulse, and s1s0 stepping 1, 2, 3, 0.
REQ-027 SHALL cover: frame_start with 0xAA, then 0xBB, then frame_start with 0x01, then 0x02, 0x03, 0x04 -> a..d=0x01..0x04, exactly one frame_valid pulse, and the first partial frame never appears on the outputs.
REQ-028 SHALL cover: rst asserted after 2 words of a frame -> next cycle all outputs 0 and s1s0=0; later words sent without frame_start are ignored.
REQ-029 SHALL cover: DEMUX_PARITY_EN defined, DW=1, data 1, 1, 0, 1 with P=1 -> commit and frame_valid pulse; the same data with P=0 -> par_err pulse and a..d unchanged.
REQ-030 SHALL cover: din_valid=0 for 100 cycles after reset -> all outputs remain 0 and state remains IDLE.
